// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Exports PC_START, REG_BUS, INST_BUS, INST_NOP, the fetch-queue entry type
// and a word-alignment helper.
package if_fetch_pkg;

  localparam int REG_BUS  = 64;
  localparam int INST_BUS = 32;

  localparam logic [REG_BUS-1:0]  PC_START = 64'h0000_0000_8000_0000;
  localparam logic [INST_BUS-1:0] INST_NOP = 32'h0000_0013;  // addi x0,x0,0

  // One fetch-queue slot: PC tagged at request time, payload filled later.
  typedef struct packed {
    logic [REG_BUS-1:0]  pc;
    logic [INST_BUS-1:0] inst;
    logic                err;
    logic                filled;
  } fq_entry_t;

  function automatic logic [REG_BUS-1:0] word_align(input logic [REG_BUS-1:0] a);
    return {a[REG_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: slot allocated at request, filled at response, popped by decode.
// Ports: alloc_i/alloc_pc_i, fill_i/fill_inst_i/fill_err_i, pop_i, flush_i;
//        head_vld_o + head fields, occ_o (allocated slots), unfilled_o (awaiting response).
module fetch_queue
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_i,
  input  logic [REG_BUS-1:0]  alloc_pc_i,
  input  logic                fill_i,
  input  logic [INST_BUS-1:0] fill_inst_i,
  input  logic                fill_err_i,
  input  logic                pop_i,
  input  logic                flush_i,
  output logic                head_vld_o,
  output logic [REG_BUS-1:0]  head_pc_o,
  output logic [INST_BUS-1:0] head_inst_o,
  output logic                head_err_o,
  output logic [CW-1:0]       occ_o,
  output logic [CW-1:0]       unfilled_o
);

  fq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [CW-1:0] occ_q, unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: '0, inst: INST_NOP, err: 1'b0, filled: 1'b0};
      end
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      unf_q      <= '0;
    end else if (flush_i) begin
      // Flush wins over any same-cycle alloc/fill/pop.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].filled <= 1'b0;
      end
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      unf_q      <= '0;
    end else begin
      // alloc and fill never target the same slot: fill only hits slots
      // already allocated, and alloc is blocked while the queue is full.
      if (alloc_i) begin
        mem_q[wr_ptr_q] <= '{pc: alloc_pc_i, inst: INST_NOP, err: 1'b0, filled: 1'b0};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (fill_i) begin
        mem_q[fill_ptr_q].inst   <= fill_inst_i;
        mem_q[fill_ptr_q].err    <= fill_err_i;
        mem_q[fill_ptr_q].filled <= 1'b1;
        fill_ptr_q               <= fill_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      occ_q <= occ_q + CW'(alloc_i) - CW'(pop_i);
      unf_q <= unf_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  assign head_vld_o  = (occ_q != '0) && mem_q[rd_ptr_q].filled;
  assign head_pc_o   = mem_q[rd_ptr_q].pc;
  assign head_inst_o = mem_q[rd_ptr_q].inst;
  assign head_err_o  = mem_q[rd_ptr_q].err;
  assign occ_o       = occ_q;
  assign unfilled_o  = unf_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the fetch PC, issues word requests, queues PC-tagged
// responses for decode, and applies execute redirects (flush + drop stale responses).
// Ports: inst_req_* request channel, inst_rsp_* response beats (never stalled),
//        redirect/redirect_pc from execute, if_*/id_ready handshake to decode.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [REG_BUS-1:0] PC_RESET = PC_START,
  parameter int                 QDEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                inst_req_valid,
  input  logic                inst_req_ready,
  output logic [REG_BUS-1:0]  inst_req_addr,
  input  logic                inst_rsp_valid,
  input  logic [INST_BUS-1:0] inst_rsp_data,
  input  logic                inst_rsp_err,
  input  logic                redirect,
  input  logic [REG_BUS-1:0]  redirect_pc,
  output logic                if_valid,
  input  logic                id_ready,
  output logic [INST_BUS-1:0] if_inst,
  output logic [REG_BUS-1:0]  if_pc,
  output logic                if_fault
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [REG_BUS-1:0]  pc_q, pc_d;
  logic [CW-1:0]       drop_q, drop_d;
  logic [CW-1:0]       occ, unfilled;
  logic                head_vld, head_err;
  logic [REG_BUS-1:0]  head_pc;
  logic [INST_BUS-1:0] head_inst;
  logic                credit_ok, req_hs, rsp_drop, rsp_fill, pop;

  // Every queued slot and every stale response still in flight holds a credit.
  assign credit_ok      = ({1'b0, occ} + {1'b0, drop_q}) < (CW + 1)'(QDEPTH);
  assign inst_req_valid = !rst && !redirect && credit_ok;
  assign inst_req_addr  = word_align(pc_q);
  assign req_hs         = inst_req_valid && inst_req_ready;

  assign rsp_drop = inst_rsp_valid && (drop_q != '0);
  assign rsp_fill = inst_rsp_valid && (drop_q == '0) && (unfilled != '0);
  assign pop      = head_vld && id_ready;

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect) begin
      pc_d = word_align(redirect_pc);
      // Unfilled slots become stale responses; a beat landing this cycle
      // (whether it would fill or was already stale) is consumed now.
      drop_d = drop_q + unfilled - CW'(rsp_drop || rsp_fill);
    end else begin
      if (req_hs) begin
        pc_d = pc_q + 64'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= PC_RESET;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_fq (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (req_hs),
    .alloc_pc_i  (inst_req_addr),
    .fill_i      (rsp_fill),
    .fill_inst_i (inst_rsp_data),
    .fill_err_i  (inst_rsp_err),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_vld_o  (head_vld),
    .head_pc_o   (head_pc),
    .head_inst_o (head_inst),
    .head_err_o  (head_err),
    .occ_o       (occ),
    .unfilled_o  (unfilled)
  );

  // Not masked by redirect: execute squashes whatever decode sees that cycle.
  assign if_valid = head_vld;
  assign if_inst  = head_vld ? head_inst : INST_NOP;
  assign if_pc    = head_vld ? head_pc : '0;
  assign if_fault = head_vld && head_err;

  // A response beat must always correspond to an outstanding request.
  a_rsp_has_owner : assert property (@(posedge clk) disable iff (rst)
    inst_rsp_valid |-> ((drop_q != '0) || (unfilled != '0)));

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk, rst;
  logic        inst_req_valid, inst_req_ready;
  logic [63:0] inst_req_addr;
  logic        inst_rsp_valid, inst_rsp_err;
  logic [31:0] inst_rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        if_valid, id_ready, if_fault;
  logic [31:0] if_inst;
  logic [63:0] if_pc;

  if_fetch dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_req_addr(inst_req_addr),
    .inst_rsp_valid(inst_rsp_valid), .inst_rsp_data(inst_rsp_data),
    .inst_rsp_err(inst_rsp_err),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .id_ready(id_ready), .if_inst(if_inst),
    .if_pc(if_pc), .if_fault(if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model and logs.
  int          cyc;
  int          lat;
  logic [63:0] err_addr;
  logic        cfg_ready, cfg_idr;
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] req_log[$];
  logic [63:0] dlv_pc[$];
  logic [31:0] dlv_inst[$];
  logic        dlv_flt[$];
  int          first_dlv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    dlv_pc.delete();
    dlv_inst.delete();
    dlv_flt.delete();
    first_dlv = -1;
  endtask

  // One clock cycle: drive inputs at the falling edge, then sample settled outputs.
  task automatic step(input logic rd = 1'b0, input logic [63:0] rpc = 64'h0);
    logic [63:0] a;
    @(negedge clk);
    cyc++;
    inst_req_ready = cfg_ready;
    id_ready       = cfg_idr;
    redirect       = rd;
    redirect_pc    = rpc;
    inst_rsp_valid = 1'b0;
    inst_rsp_data  = 32'h0;
    inst_rsp_err   = 1'b0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      inst_rsp_valid = 1'b1;
      inst_rsp_data  = a[31:0];
      inst_rsp_err   = (a == err_addr);
    end
    #1;
    if (inst_req_valid && inst_req_ready) begin
      req_log.push_back(inst_req_addr);
      pend_addr.push_back(inst_req_addr);
      pend_due.push_back(cyc + lat);
    end
    if (if_valid && id_ready) begin
      if (first_dlv < 0) first_dlv = cyc;
      dlv_pc.push_back(if_pc);
      dlv_inst.push_back(if_inst);
      dlv_flt.push_back(if_fault);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    inst_req_ready = 1'b0;
    inst_rsp_valid = 1'b0;
    redirect       = 1'b0;
    id_ready       = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    clear_logs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int stale_cnt(input logic [63:0] lo);
    int s = 0;
    foreach (dlv_pc[i]) if (dlv_pc[i] < lo) s++;
    return s;
  endfunction

  initial begin
    rst = 1'b1; inst_req_ready = 1'b0; inst_rsp_valid = 1'b0;
    inst_rsp_data = 32'h0; inst_rsp_err = 1'b0; redirect = 1'b0;
    redirect_pc = 64'h0; id_ready = 1'b0;
    cyc = 0; lat = 1; err_addr = 64'h1; cfg_ready = 1'b1; cfg_idr = 1'b1;
    clear_logs();

    // Reset values
    #13;
    chk("rst_req_valid", {63'h0, inst_req_valid}, 64'h0);
    chk("rst_if_valid",  {63'h0, if_valid}, 64'h0);
    chk("rst_if_inst",   {32'h0, if_inst}, 64'h13);
    chk("rst_if_pc",     if_pc, 64'h0);
    chk("rst_if_fault",  {63'h0, if_fault}, 64'h0);

    // Streaming, 1-cycle memory
    do_reset();
    lat = 1; cfg_ready = 1'b1; cfg_idr = 1'b1;
    run(12);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("seq_req%0d", i), req_log[i], 64'h8000_0000 + 64'(4 * i));
      chk($sformatf("seq_pc%0d", i), dlv_pc[i], 64'h8000_0000 + 64'(4 * i));
      chk($sformatf("seq_inst%0d", i), {32'h0, dlv_inst[i]}, 64'h8000_0000 + 64'(4 * i));
    end
    chk("seq_first_cycle", 64'(first_dlv), 64'd3);
    chk("seq_throughput", 64'(dlv_pc.size()), 64'd10);

    // Decode stall: queue fills to QDEPTH, then drains in order
    do_reset();
    lat = 1; cfg_ready = 1'b1; cfg_idr = 1'b0;
    run(10);
    chk("stall_req_cnt", 64'(req_log.size()), 64'd4);
    chk("stall_req_valid", {63'h0, inst_req_valid}, 64'h0);
    chk("stall_head_valid", {63'h0, if_valid}, 64'h1);
    chk("stall_head_pc", if_pc, 64'h8000_0000);
    cfg_idr = 1'b1;
    run(12);
    chk("drain_enough", 64'(dlv_pc.size() >= 6), 64'h1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("drain_pc%0d", i), dlv_pc[i], 64'h8000_0000 + 64'(4 * i));
      chk($sformatf("drain_inst%0d", i), {32'h0, dlv_inst[i]}, 64'h8000_0000 + 64'(4 * i));
    end

    // Redirect with two responses outstanding
    do_reset();
    lat = 1; cfg_ready = 1'b1; cfg_idr = 1'b1;
    run(4);              // 0x00..0x0C, answered quickly
    lat = 5;
    run(2);              // 0x10, 0x14 held in flight
    chk("redir_out_10", req_log[4], 64'h8000_0010);
    chk("redir_out_14", req_log[5], 64'h8000_0014);
    step(1'b1, 64'h8000_1002);
    clear_logs();
    lat = 1;
    run(14);
    chk("redir_req0", req_log[0], 64'h8000_1000);
    chk("redir_pc0", dlv_pc[0], 64'h8000_1000);
    chk("redir_inst0", {32'h0, dlv_inst[0]}, 64'h8000_1000);
    chk("redir_pc1", dlv_pc[1], 64'h8000_1004);
    chk("redir_stale", 64'(stale_cnt(64'h8000_1000)), 64'h0);

    // Redirect in the same cycle as a live response
    do_reset();
    lat = 2; cfg_ready = 1'b1; cfg_idr = 1'b1;
    run(2);              // 0x00 due c3, 0x04 due c4
    step(1'b1, 64'h8000_2000);
    clear_logs();
    run(10);
    chk("rsr_req0", req_log[0], 64'h8000_2000);
    chk("rsr_pc0", dlv_pc[0], 64'h8000_2000);
    chk("rsr_inst0", {32'h0, dlv_inst[0]}, 64'h8000_2000);
    chk("rsr_pc1", dlv_pc[1], 64'h8000_2004);
    chk("rsr_stale", 64'(stale_cnt(64'h8000_2000)), 64'h0);

    // Access fault on 0x80000008 only
    do_reset();
    lat = 1; cfg_ready = 1'b1; cfg_idr = 1'b1; err_addr = 64'h8000_0008;
    run(8);
    chk("err_pc2", dlv_pc[2], 64'h8000_0008);
    chk("err_flt2", {63'h0, dlv_flt[2]}, 64'h1);
    chk("err_flt1", {63'h0, dlv_flt[1]}, 64'h0);
    chk("err_flt3", {63'h0, dlv_flt[3]}, 64'h0);
    err_addr = 64'h1;

    // Asynchronous reset mid-burst with 3 outstanding
    do_reset();
    lat = 3; cfg_ready = 1'b1; cfg_idr = 1'b0;
    run(4);
    chk("arst_outstanding", 64'(pend_addr.size()), 64'd3);
    @(posedge clk);
    #2;
    chk("arst_pre_valid", {63'h0, if_valid}, 64'h1);
    chk("arst_pre_pc", if_pc, 64'h8000_0000);
    rst = 1'b1;
    inst_rsp_valid = 1'b0;
    #1;
    chk("arst_req_valid", {63'h0, inst_req_valid}, 64'h0);
    chk("arst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("arst_if_inst", {32'h0, if_inst}, 64'h13);
    chk("arst_if_pc", if_pc, 64'h0);
    chk("arst_if_fault", {63'h0, if_fault}, 64'h0);
    do_reset();          // model forgets the stale in-flight responses
    lat = 1; cfg_idr = 1'b1;
    run(4);
    chk("arst_req0", req_log[0], 64'h8000_0000);
    chk("arst_pc0", dlv_pc[0], 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
